// File: rtl/mt_periph_pkg.sv
// Shared definitions for the prefetching Mersenne Twister peripheral:
// register map, STATUS/CTRL bit positions and the fill FSM state type.
package mt_periph_pkg;

    localparam logic [3:0] ADDR_RAND   = 4'h0;
    localparam logic [3:0] ADDR_SEED   = 4'h4;
    localparam logic [3:0] ADDR_STATUS = 4'h8;
    localparam logic [3:0] ADDR_CTRL   = 4'hC;

    localparam int STAT_BUSY_BIT  = 31;
    localparam int STAT_FULL_BIT  = 30;
    localparam int STAT_EMPTY_BIT = 29;

    localparam int CTRL_FILL_EN_BIT = 0;
    localparam int CTRL_FLUSH_BIT   = 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        SEEDING
    } mt_fill_state_t;

endpackage

// File: rtl/bus_protocol_if.sv
// Simple single-cycle peripheral bus: read/write enables, byte address,
// write data in, combinational read data and error out.
interface bus_protocol_if;

    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        error;

    modport peripheral_vital (
        input  ren, wen, addr, wdata,
        output rdata, error
    );

    modport controller (
        output ren, wen, addr, wdata,
        input  rdata, error
    );

endinterface

// File: rtl/mersenne_twister.sv
// MT19937 core. The twist is done one word at a time: each gen_rv step
// rewrites mt[idx] and advances idx, and rv always presents the tempered
// value that step will produce, so a consumer can capture rv on the same
// edge that gen_rv advances the state. A load_value re-seeds the state one
// word per cycle over the following 623 cycles.
module mersenne_twister (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        gen_rv,
    input  logic        load_value,
    input  logic [31:0] value,
    output logic [31:0] rv
);

    localparam int N = 624;
    localparam int M = 397;
    localparam logic [31:0] MATRIX_A   = 32'h9908_B0DF;
    localparam logic [31:0] UPPER_MASK = 32'h8000_0000;
    localparam logic [31:0] LOWER_MASK = 32'h7FFF_FFFF;
    localparam logic [31:0] INIT_MULT  = 32'd1812433253;
    localparam logic [31:0] RESET_SEED = 32'd5489;

    function automatic logic [31:0] init_step(input logic [31:0] prev, input logic [9:0] i);
        return INIT_MULT * (prev ^ (prev >> 30)) + {22'd0, i};
    endfunction

    function automatic logic [31:0] temper(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x >> 11);
        t = t ^ ((t << 7) & 32'h9D2C_5680);
        t = t ^ ((t << 15) & 32'hEFC6_0000);
        t = t ^ (t >> 18);
        return t;
    endfunction

    // Seeded state for the default seed, so the core can generate straight out of reset.
    function automatic logic [N*32-1:0] reset_table(input logic [31:0] seed);
        logic [N*32-1:0] t;
        logic [31:0]     w;
        t        = '0;
        w        = seed;
        t[31:0]  = w;
        for (int i = 1; i < N; i++) begin
            w = init_step(w, 10'(i));
            t[i*32 +: 32] = w;
        end
        return t;
    endfunction

    localparam logic [N*32-1:0] RESET_STATE = reset_table(RESET_SEED);

    logic [31:0] mt [N];
    logic [9:0]  idx;
    logic [9:0]  seed_idx;
    logic        seeding;
    logic [9:0]  idx_next;
    logic [9:0]  idx_far;
    logic [31:0] mix;
    logic [31:0] twisted;

    // Twist of the current word and its tempered output.
    always_comb begin
        idx_next = (idx == 10'(N - 1)) ? 10'd0 : idx + 10'd1;
        idx_far  = (idx >= 10'(N - M)) ? idx - 10'(N - M) : idx + 10'(M);
        mix      = (mt[idx] & UPPER_MASK) | (mt[idx_next] & LOWER_MASK);
        twisted  = mt[idx_far] ^ (mix >> 1) ^ (mix[0] ? MATRIX_A : 32'd0);
        rv       = temper(twisted);
    end

    // State array: reset image, seed load, incremental seeding, or one twist step.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < N; i++) begin
                mt[i] <= RESET_STATE[i*32 +: 32];
            end
            idx      <= '0;
            seed_idx <= '0;
            seeding  <= 1'b0;
        end else if (load_value) begin
            mt[0]    <= value;
            idx      <= '0;
            seed_idx <= 10'd1;
            seeding  <= 1'b1;
        end else if (seeding) begin
            mt[seed_idx] <= init_step(mt[seed_idx - 10'd1], seed_idx);
            seed_idx     <= seed_idx + 10'd1;
            if (seed_idx == 10'(N - 1)) begin
                seeding <= 1'b0;
            end
        end else if (gen_rv) begin
            mt[idx] <= twisted;
            idx     <= idx_next;
        end
    end

endmodule

// File: rtl/mt_word_fifo.sv
// 32-bit x DEPTH synchronous FIFO with a first-word-fall-through head.
// Flush wins over any push or pop in the same cycle. Count is kept in its
// own register so full and empty need no pointer comparison.
module mt_word_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rdata   = mem[rd_ptr];

    // Pointers and fill count; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Word storage; contents are only meaningful below the count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mt_prefetch_periph.sv
// Bus-attached MT19937 peripheral. A fill FSM keeps a prefetch FIFO topped
// up from the core so RAND reads return a word with no wait states. SEED
// flushes the FIFO, reloads the core and holds generation off for
// SEED_WAIT cycles while the core rebuilds its state.
module mt_prefetch_periph import mt_periph_pkg::*; #(
    parameter int DEPTH     = 8,
    parameter int SEED_WAIT = 624,
    parameter int CNT_W     = $clog2(DEPTH) + 1
) (
    input logic                      clk,
    input logic                      n_rst,
    bus_protocol_if.peripheral_vital busif
);

    localparam int SW_W = (SEED_WAIT > 1) ? $clog2(SEED_WAIT) : 1;

    mt_fill_state_t   state;
    mt_fill_state_t   state_nxt;
    logic             fill_en;
    logic [SW_W-1:0]  seed_cnt;
    logic             load_value;
    logic [31:0]      seed_value;
    logic             gen_rv;
    logic [31:0]      rv;

    logic             fifo_pop;
    logic             fifo_flush;
    logic             fifo_full;
    logic             fifo_empty;
    logic [31:0]      fifo_rdata;
    logic [CNT_W-1:0] fifo_count;

    logic [3:0]       reg_sel;
    logic             addr_ok;
    logic             rd_req;
    logic             wr_req;
    logic             rand_rd;
    logic             seed_wr;
    logic             status_rd;
    logic             ctrl_rd;
    logic             ctrl_wr;
    logic [31:0]      status_word;

    // Register decode; only the four word addresses below 0x10 are legal.
    always_comb begin
        reg_sel   = busif.addr[3:0];
        addr_ok   = (busif.addr[31:4] == '0);
        rd_req    = busif.ren & ~busif.wen & addr_ok;
        wr_req    = busif.wen & ~busif.ren & addr_ok;
        rand_rd   = rd_req & (reg_sel == ADDR_RAND);
        status_rd = rd_req & (reg_sel == ADDR_STATUS);
        ctrl_rd   = rd_req & (reg_sel == ADDR_CTRL);
        seed_wr   = wr_req & (reg_sel == ADDR_SEED);
        ctrl_wr   = wr_req & (reg_sel == ADDR_CTRL);
        fifo_flush = seed_wr | (ctrl_wr & busif.wdata[CTRL_FLUSH_BIT]);
    end

    // STATUS word assembly.
    always_comb begin
        status_word                 = '0;
        status_word[STAT_BUSY_BIT]  = (state == SEEDING);
        status_word[STAT_FULL_BIT]  = fifo_full;
        status_word[STAT_EMPTY_BIT] = fifo_empty;
        status_word[CNT_W-1:0]      = fifo_count;
    end

    // Zero-wait read data, pop request and error flag.
    always_comb begin
        busif.rdata = '0;
        busif.error = 1'b0;
        fifo_pop    = 1'b0;
        if (rand_rd) begin
            if (!fifo_empty) begin
                busif.rdata = fifo_rdata;
                fifo_pop    = 1'b1;
            end else begin
                busif.error = 1'b1;
            end
        end else if (status_rd) begin
            busif.rdata = status_word;
        end else if (ctrl_rd) begin
            busif.rdata[CTRL_FILL_EN_BIT] = fill_en;
        end else if (!(seed_wr | ctrl_wr) && (busif.ren | busif.wen)) begin
            busif.error = 1'b1;
        end
    end

    // Fill FSM next state and generate strobe. "Stays full" accounts for a
    // pop this cycle so a steady read stream keeps the FSM in FILL.
    always_comb begin
        state_nxt = state;
        gen_rv    = 1'b0;
        case (state)
            IDLE: begin
                if (seed_wr) begin
                    state_nxt = SEEDING;
                end else if (fill_en && !(fifo_full && !fifo_pop)) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (seed_wr) begin
                    state_nxt = SEEDING;
                end else begin
                    gen_rv = ~fifo_full & fill_en;
                    if ((fifo_full && !fifo_pop) || !fill_en) begin
                        state_nxt = IDLE;
                    end
                end
            end
            SEEDING: begin
                if (!seed_wr && seed_cnt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, settle counter, fill enable and the seed-load strobe.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            seed_cnt   <= '0;
            fill_en    <= 1'b1;
            load_value <= 1'b0;
        end else begin
            state      <= state_nxt;
            load_value <= seed_wr;
            if (seed_wr) begin
                seed_cnt <= SW_W'(SEED_WAIT - 1);
            end else if (state == SEEDING && seed_cnt != '0) begin
                seed_cnt <= seed_cnt - SW_W'(1);
            end
            if (ctrl_wr) begin
                fill_en <= busif.wdata[CTRL_FILL_EN_BIT];
            end
        end
    end

    // Seed word captured alongside the load strobe.
    always_ff @(posedge clk) begin
        if (seed_wr) seed_value <= busif.wdata;
    end

    mersenne_twister u_core (
        .clk        (clk),
        .n_rst      (n_rst),
        .gen_rv     (gen_rv),
        .load_value (load_value),
        .value      (seed_value),
        .rv         (rv)
    );

    mt_word_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (gen_rv),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .wdata (rv),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: doc/mt_prefetch_periph.md
# mt_prefetch_periph

Bus-attached Mersenne Twister peripheral that decouples random-number generation from bus reads. A fill FSM drives one `mersenne_twister` core and keeps a `DEPTH`-entry prefetch FIFO topped up, so bus reads pop a word in zero wait cycles. Seeding is managed with a programmable settle interval. Control and status registers expose fill enable, flush, busy and fill level. The block sits on the peripheral bus in place of the single-word PRNG wrapper.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `SEED_WAIT`, 624: cycles after a seed load before generation resumes; ≥1.
- `CNT_W`, `$clog2(DEPTH)+1`: width of the fill-level field (derived).
- `clk`  in  1  system clock.
- `n_rst`  in  1  reset; asynchronous, active-low.
- `busif`  modport `bus_protocol_if.peripheral_vital`  —  uses `ren`, `wen`, `addr`, `wdata`, `rdata`, `error`.

## Operation
- Address decode is on `addr[3:0]`.
- **0x0, read-only (RAND):**
  - FIFO non-empty: `rdata` = head word; pop on that cycle.
  - FIFO empty: `error`=1, `rdata`=0, no pop.
- **0x4, write-only (SEED):**
  - Flush the FIFO.
  - Pulse `load_value` for 1 cycle with `value=wdata`.
  - Enter SEEDING.
- **0x8, read-only (STATUS):**
  - bit31 = busy (state==SEEDING).
  - bit30 = full.
  - bit29 = empty.
  - `[CNT_W-1:0]` = fill count.
  - Other bits 0.
- **0xC, read/write (CTRL):**
  - bit0 = fill_en, reset value 1.
  - bit1 = flush; write-1 empties the FIFO, is self-clearing and always reads 0.
- **Errors** (`error`=1, no side effect):
  - Any other address.
  - Write to 0x0 or 0x8.
  - Read of 0x4.
  - `ren` and `wen` both high in the same cycle.
- **FSM states:**
  - IDLE:
    - fill_en=1 and not full → FILL.
    - A SEED write → SEEDING.
  - FILL:
    - `gen_rv`=1 each cycle while count<DEPTH and fill_en=1.
    - `rv` is pushed at the same clock edge.
    - Full or fill_en=0 → IDLE.
    - SEED write → SEEDING (takes priority over push).
  - SEEDING:
    - Counter loads `SEED_WAIT-1` and decrements; `gen_rv`=0.
    - At zero → IDLE.
    - A new SEED write restarts the counter.
- **Push and pop:**
  - A push is issued only when count<DEPTH, evaluated before that cycle's pop.
  - Push and pop in the same cycle leave count unchanged.
  - A pop from a full FIFO does not enable a push in the same cycle.
- **Flush:** a flush (CTRL bit1 or SEED) in the same cycle as a pop or push discards both; count becomes 0.
- **Pointers:** `log2(DEPTH)` bits, wrapping naturally; count is a separate `CNT_W`-bit register.
- **fill_en=0:** FIFO contents are retained and still readable.

## Timing
- **Reset values:**
  - `rdata`=0, `error`=0.
  - FIFO empty, count=0, fill_en=1.
  - State IDLE, `load_value`=0, `gen_rv`=0.
  - The core's reset seed applies.
- **After reset:** first cycle after `n_rst` deasserts moves IDLE→FILL; first push on the following edge. The FIFO is full `DEPTH`+1 cycles after reset.
- **Read latency:** `rdata` and `error` are combinational on `ren`/`addr` (0 wait states); the pop commits at the rising edge.
- **Seeding latency:** SEED write at edge N. `load_value` is high during cycle N. The first `gen_rv` is in cycle N+`SEED_WAIT`+1 (SEEDING→IDLE→FILL).
- **Idle outputs:** `rdata`=0 when not reading a valid address.
- **Mid-operation reset:** an asynchronous `n_rst` during any state clears everything immediately; no partial push.

## Structure
- Package `mt_periph_pkg` holds:
  - address constants `ADDR_RAND`, `ADDR_SEED`, `ADDR_STATUS`, `ADDR_CTRL`;
  - `typedef enum logic [1:0] {IDLE, FILL, SEEDING} mt_fill_state_t`;
  - STATUS bit-position constants.
- Sub-module `mt_word_fifo`: synchronous FIFO, 32-bit × `DEPTH`.
  - Inputs: `push`, `pop`, `flush`, `wdata`.
  - Outputs: `rdata`, `full`, `empty`, `count`.
- The top level contains the FSM, seed counter, register decode and the `mersenne_twister` instance.

## Test plan
- **Reset fill:** release reset, idle 10 cycles → STATUS=0x4000_0008 (full, count 8). `gen_rv` pulses exactly 8 times.
- **Back-to-back reads:** 8 reads of 0x0 with fill_en=1 → 8 words matching the golden MT19937 sequence for the default seed, in order. No error; count stays ≥7.
- **Drain:** CTRL=0 (fill off), then 9 reads of 0x0 → first 8 return data; the 9th gives `error`=1 and `rdata`=0. STATUS then reads 0x2000_0000.
- **Seed 5489:** write 0x4=5489 → busy=1 and count=0 for `SEED_WAIT` cycles. The first read after refill equals 0xD091BB5C (MT19937 first output for seed 5489).
- **Boundaries:** pop on the same cycle as a push at count=4 → count stays 4. Flush and pop in the same cycle at count=8 → count=0, no error.
- **Illegal accesses:** read 0x4, write 0x8, access 0x10, and `ren`+`wen` together → `error`=1 each time; state and FIFO unchanged.
